vga_line_fetch: RTL and testbench
=================================

VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 SHALL have port CLK_50  in  1  system clock; the only clock in the block.
REQ-002 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-003 SHALL have port pix_tick  in  1  pixel-advance strobe from the sync generator.
REQ-004 SHALL have port pixel_x  in  10  current horizontal counter, 0..799.
REQ-005 SHALL have port pixel_y  in  10  current vertical counter, 0..524.
REQ-006 SHALL have port in_display  in  1  high inside the 640x480 active area.
REQ-007 SHALL have port mem_req  out  1  video-RAM read request.
REQ-008 SHALL have port mem_addr  out  15  word address, valid while mem_req=1.
REQ-009 SHALL have port mem_ready  in  1  RAM accepts the request this cycle when mem_req&mem_ready.
REQ-010 SHALL have port mem_valid  in  1  read data strobe; responses return in request order, at least 1 cycle after acceptance.
REQ-011 SHALL have port mem_rdata  in  16  read data, 1bpp, bit n = pixel (16*word+n).
REQ-012 SHALL have port pixel_out  out  16  word covering the current pixel_x, feeding the VGA output stage pixel_in.
REQ-013 SHALL have port underflow  out  1  sticky flag: a line fetch missed its deadline.

Function
REQ-014 SHALL hold two 40x16 line banks (ping-pong): read_bank drives the display, and the other bank is filled.
REQ-015 Line-start event SHALL be defined as pix_tick=1 with pixel_x=0.
REQ-016 On line-start, the block SHALL toggle read_bank and compute the target line: pixel_y=524 -> 0, else pixel_y+1; fetch starts only if the target is below 480.
REQ-017 FSM states SHALL be IDLE, REQ, DRAIN, FLUSH.
REQ-018 IDLE->REQ SHALL occur on a line-start with a valid target; the word index and the outstanding count are cleared.
REQ-019 In REQ, mem_req=1 and mem_addr=target*40+word_idx; each accepted beat increments word_idx; after the 40th accept the FSM SHALL go to DRAIN.
REQ-020 Outstanding requests SHALL be capped at 2; mem_req SHALL be deasserted while 2 are outstanding.
REQ-021 Each mem_valid SHALL write mem_rdata to fill bank[resp_idx], with resp_idx 0..39 in order.
REQ-022 DRAIN->IDLE SHALL occur when the 40th response is written; the fill bank's valid bit is then set.
REQ-023 The fill bank's valid bit SHALL be cleared when a fetch into it starts.
REQ-024 If a line-start occurs outside IDLE: underflow<=1, the banks still swap, and the FSM goes to FLUSH.
REQ-025 In FLUSH, mem_req=0 and responses are discarded; when outstanding=0 the FSM SHALL go to REQ for the latched new target.
REQ-026 pixel_out SHALL be registered with a latency of 1 cycle: bank[read_bank][pixel_x[9:4]] when in_display and the read bank is valid, else 16'h0000.
REQ-027 Simultaneous mem_valid and line-start SHALL have the response counted and written before the FLUSH decision.
REQ-028 mem_valid arriving in IDLE SHALL be ignored.
REQ-029 underflow SHALL clear only on RESET.

Reset
REQ-030 On RESET=1 at a CLK_50 edge, the following SHALL be set: FSM=IDLE, mem_req=0, mem_addr=0, pixel_out=0, underflow=0, read_bank=0, both bank-valid bits=0, and counters=0.
REQ-031 Bank contents SHALL NOT be reset.
REQ-032 RESET mid-fetch SHALL abandon the fetch; in-flight responses after reset SHALL be ignored, because the state is IDLE.

Structure
REQ-033 Package vga_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, V_LAST=524, WORDS_PER_LINE=40, ADDR_W=15, and the FSM state enum.
REQ-034 One sub-module vga_line_bank SHALL implement the 2x40x16 storage: a single write port, a single registered read port, and inference-friendly RAM.
REQ-035 The target*40 computation SHALL use (target<<5)+(target<<3) at 15-bit width.

Verification
REQ-036 Scenario: zero-wait RAM, line-start at pixel_y=9 -> 40 requests with addresses 400..439; the bank becomes valid; underflow stays 0.
REQ-037 Scenario: mem_ready toggling 1/0 and responses delayed 3 cycles -> at most 2 outstanding; data lands at index order; pixel_out at pixel_x=17 equals word 1 of line 10.
REQ-038 Scenario: line-start at pixel_y=524 -> target 0, mem_addr starts at 0; line-start at pixel_y=479..523 -> no mem_req.
REQ-039 Scenario: mem_ready held 0 across the next line-start -> underflow=1, FSM passes through FLUSH, the following fetch completes, and pixel_out=0 for the unfilled line.
REQ-040 Scenario: RESET asserted with 1 outstanding beat -> all outputs 0 the next cycle; the late mem_valid causes no bank write.
REQ-041 Scenario: in_display=0 -> pixel_out=16'h0000 one cycle later, regardless of bank content.

Source files
------------

// File: rtl/vga_line_fetch_pkg.sv
// Shared constants, fetch FSM states and line address helper for the VGA line fetcher.
package vga_pkg;
  localparam int H_ACTIVE       = 640;
  localparam int V_ACTIVE       = 480;
  localparam int V_LAST         = 524;
  localparam int WORDS_PER_LINE = 40;
  localparam int ADDR_W         = 15;
  localparam int WIDX_W         = 6;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    FLUSH
  } fetch_state_e;

  // line*40 as shift-add so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] line_base(input logic [9:0] line);
    logic [ADDR_W-1:0] l;
    l = ADDR_W'(line);
    return (l << 5) + (l << 3);
  endfunction
endpackage

// File: rtl/vga_line_fetch_if.sv
// Video-RAM read bus: request/accept handshake plus in-order read data strobe.
interface vga_line_fetch_if;
  import vga_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_valid;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_valid,
    output mem_rdata
  );
endinterface

// File: rtl/vga_line_bank.sv
// Ping-pong pair of 40x16 line buffers: one write port, one registered read port.
module vga_line_bank
  import vga_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              wbank_i,
  input  logic [WIDX_W-1:0] waddr_i,
  input  logic [15:0]       wdata_i,
  input  logic              rbank_i,
  input  logic [WIDX_W-1:0] raddr_i,
  output logic [15:0]       rdata_o
);
  logic [15:0] mem_q [2][WORDS_PER_LINE];
  logic [15:0] rdata_q;

  // no reset on the storage so it maps onto block RAM
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wbank_i][waddr_i] <= wdata_i;
    rdata_q <= mem_q[rbank_i][raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/vga_line_fetch.sv
// Prefetches the next display line from video RAM into a ping-pong line buffer
// and serves the 16-pixel word under the beam to the VGA output stage.
//
// state | meaning
// IDLE  | no fetch in progress
// REQ   | issuing 40 read requests, at most 2 outstanding
// DRAIN | all requests accepted, collecting remaining responses
// FLUSH | deadline missed, discarding in-flight responses before refetch
module vga_line_fetch
  import vga_pkg::*;
(
  input  logic                     CLK_50,
  input  logic                     RESET,
  input  logic                     pix_tick,
  input  logic [9:0]               pixel_x,
  input  logic [9:0]               pixel_y,
  input  logic                     in_display,
  vga_line_fetch_if.master         mem,
  output logic [15:0]              pixel_out,
  output logic                     underflow
);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS_PER_LINE - 1);

  fetch_state_e      state_q, state_d;
  logic [WIDX_W-1:0] word_q, word_d, resp_q, resp_d;
  logic [1:0]        out_q, out_d;
  logic              read_bank_q, read_bank_d;
  logic [1:0]        valid_q, valid_d;
  logic [9:0]        target_q, target_d;
  logic              target_ok_q, target_ok_d;
  logic              underflow_q, underflow_d;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              sel_q;
  logic [15:0]       bank_rdata;

  logic       line_start, accept, resp_take, bank_we, fetch_done, next_ok;
  logic [9:0] next_line;

  assign line_start = pix_tick && (pixel_x == 10'd0);
  assign next_line  = (pixel_y == 10'(V_LAST)) ? 10'd0 : pixel_y + 10'd1;
  assign next_ok    = next_line < 10'(V_ACTIVE);
  assign accept     = mem_req_q && mem.mem_ready;
  assign resp_take  = mem.mem_valid && (state_q != IDLE);
  assign bank_we    = resp_take && ((state_q == REQ) || (state_q == DRAIN));
  assign fetch_done = bank_we && (state_q == DRAIN) && (resp_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    resp_d      = resp_q;
    out_d       = out_q + 2'(accept) - 2'(resp_take);
    read_bank_d = read_bank_q;
    valid_d     = valid_q;
    target_d    = target_q;
    target_ok_d = target_ok_q;
    underflow_d = underflow_q;
    if (accept)  word_d = word_q + 1'b1;
    if (bank_we) resp_d = resp_q + 1'b1;

    case (state_q)
      REQ:   if (accept && (word_q == LAST_IDX)) state_d = DRAIN;
      DRAIN: if (fetch_done) begin
        state_d               = IDLE;
        valid_d[~read_bank_q] = 1'b1;
      end
      FLUSH: if (out_q == 2'd0) begin
        if (target_ok_q) begin
          state_d               = REQ;
          word_d                = '0;
          resp_d                = '0;
          valid_d[~read_bank_q] = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    // a response landing in the same cycle completes the fetch before the deadline test
    if (line_start) begin
      read_bank_d = ~read_bank_q;
      target_d    = next_line;
      target_ok_d = next_ok;
      if ((state_q == IDLE) || fetch_done) begin
        if (next_ok) begin
          state_d              = REQ;
          word_d               = '0;
          resp_d               = '0;
          out_d                = '0;
          valid_d[read_bank_q] = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end else begin
        underflow_d = 1'b1;
        state_d     = FLUSH;
      end
    end
  end

  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      state_q     <= IDLE;
      word_q      <= '0;
      resp_q      <= '0;
      out_q       <= '0;
      read_bank_q <= 1'b0;
      valid_q     <= '0;
      target_q    <= '0;
      target_ok_q <= 1'b0;
      underflow_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      sel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      resp_q      <= resp_d;
      out_q       <= out_d;
      read_bank_q <= read_bank_d;
      valid_q     <= valid_d;
      target_q    <= target_d;
      target_ok_q <= target_ok_d;
      underflow_q <= underflow_d;
      mem_req_q   <= (state_d == REQ) && (out_d < 2'd2);
      mem_addr_q  <= line_base(target_d) + ADDR_W'(word_d);
      sel_q       <= in_display && valid_q[read_bank_q];
    end
  end

  vga_line_bank u_bank (
    .clk_i   (CLK_50),
    .we_i    (bank_we),
    .wbank_i (~read_bank_q),
    .waddr_i (resp_q),
    .wdata_i (mem.mem_rdata),
    .rbank_i (read_bank_q),
    .raddr_i (pixel_x[9:4]),
    .rdata_o (bank_rdata)
  );

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign pixel_out    = sel_q ? bank_rdata : 16'h0000;
  assign underflow    = underflow_q;
endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch with an in-order video-RAM responder model.
module tb_vga_line_fetch;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_tick;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        in_display;
  logic [15:0] pixel_out;
  logic        underflow;

  vga_line_fetch_if mem_bus ();

  vga_line_fetch dut (
    .CLK_50     (clk),
    .RESET      (rst),
    .pix_tick   (pix_tick),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .in_display (in_display),
    .mem        (mem_bus),
    .pixel_out  (pixel_out),
    .underflow  (underflow)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input int a);
    return 16'((a * 40503) ^ 32'h5A3C);
  endfunction

  typedef struct packed {
    logic [14:0] addr;
    int          due;
  } beat_t;

  beat_t       pend[$];
  beat_t       nb;
  logic [14:0] acc_addrs[$];
  int cyc = 0, lat = 1, ready_mode = 1, single_left = 0;
  int acc_cnt = 0, ret_cnt = 0, max_out = 0;

  // responder: ready pattern per mode, fixed latency keeps responses in order
  initial begin
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_valid = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_bus.mem_valid = 1'b0;
      mem_bus.mem_rdata = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_rdata = word_of(int'(pend[0].addr));
        void'(pend.pop_front());
        ret_cnt++;
      end
      case (ready_mode)
        0:       mem_bus.mem_ready = 1'b0;
        1:       mem_bus.mem_ready = 1'b1;
        2:       mem_bus.mem_ready = (cyc % 2 == 1);
        default: mem_bus.mem_ready = (single_left > 0);
      endcase
      if (mem_bus.mem_req === 1'b1 && mem_bus.mem_ready) begin
        nb.addr = mem_bus.mem_addr;
        nb.due  = cyc + lat;
        pend.push_back(nb);
        acc_addrs.push_back(mem_bus.mem_addr);
        acc_cnt++;
        if (single_left > 0) single_left--;
      end
      if (acc_cnt - ret_cnt > max_out) max_out = acc_cnt - ret_cnt;
    end
  end

  task automatic line_start(input int y);
    @(negedge clk);
    pix_tick = 1'b1;
    pixel_x  = 10'd0;
    pixel_y  = 10'(y);
    @(negedge clk);
    pix_tick = 1'b0;
  endtask

  task automatic pix_check(input string tag, input int x, input logic disp, input logic [15:0] exp);
    @(negedge clk);
    in_display = disp;
    pixel_x    = 10'(x);
    @(negedge clk);
    check_val(tag, pixel_out, exp);
  endtask

  task automatic wait_fetch(input int r0);
    int n = 0;
    while (ret_cnt - r0 < 40 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_val("fetch_beats", ret_cnt - r0, 40);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_addrs(input string tag, input int a0, input int base);
    int bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (a0 + i >= acc_addrs.size()) bad++;
      else if (int'(acc_addrs[a0 + i]) != base + i) bad++;
    end
    check_val(tag, bad, 0);
  endtask

  int a0, r0, n;

  initial begin
    rst = 1'b1; pix_tick = 1'b0; pixel_x = '0; pixel_y = '0; in_display = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_mem_req", mem_bus.mem_req, 0);
    check_val("rst_mem_addr", mem_bus.mem_addr, 0);
    check_val("rst_pixel_out", pixel_out, 0);
    check_val("rst_underflow", underflow, 0);
    rst = 1'b0;

    // zero-wait fetch of line 10
    lat = 1; ready_mode = 1; a0 = acc_cnt; r0 = ret_cnt;
    line_start(9);
    wait_fetch(r0);
    check_addrs("addr_line10", a0, 400);
    check_val("first_addr_line10", acc_addrs[a0], 400);
    check_val("underflow_line10", underflow, 0);
    check_val("idle_after_line10", mem_bus.mem_req, 0);

    // toggling ready, 3-cycle latency while displaying line 10
    lat = 3; ready_mode = 2; max_out = 0; a0 = acc_cnt; r0 = ret_cnt;
    line_start(10);
    pix_check("px17_line10", 17, 1'b1, word_of(401));
    pix_check("px0_line10", 0, 1'b1, word_of(400));
    pix_check("px639_line10", 639, 1'b1, word_of(439));
    pix_check("nodisp_line10", 17, 1'b0, 16'h0000);
    wait_fetch(r0);
    check_addrs("addr_line11", a0, 440);
    check_val("max_out_toggle", max_out, 2);

    // ready always high with long latency: cap must hold at 2
    lat = 4; ready_mode = 1; max_out = 0; a0 = acc_cnt; r0 = ret_cnt;
    line_start(11);
    pix_check("px17_line11", 17, 1'b1, word_of(441));
    wait_fetch(r0);
    check_addrs("addr_line12", a0, 480);
    check_val("max_out_capped", max_out, 2);

    // vertical blanking: no requests
    lat = 1; a0 = acc_cnt;
    for (int y = 479; y <= 523; y++) line_start(y);
    repeat (3) @(negedge clk);
    check_val("no_req_vblank", acc_cnt - a0, 0);
    check_val("vblank_mem_req", mem_bus.mem_req, 0);

    // wrap from last line to line 0
    a0 = acc_cnt; r0 = ret_cnt;
    line_start(524);
    check_val("wrap_req", mem_bus.mem_req, 1);
    check_val("wrap_addr", mem_bus.mem_addr, 0);
    wait_fetch(r0);
    check_addrs("addr_line0", a0, 0);

    // missed deadline
    ready_mode = 0;
    line_start(0);
    pix_check("px20_line0", 20, 1'b1, word_of(1));
    repeat (8) @(negedge clk);
    check_val("stall_req", mem_bus.mem_req, 1);
    check_val("stall_addr", mem_bus.mem_addr, 40);
    check_val("no_underflow_yet", underflow, 0);
    a0 = acc_cnt; r0 = ret_cnt;
    line_start(1);
    check_val("underflow_set", underflow, 1);
    check_val("flush_no_req", mem_bus.mem_req, 0);
    @(negedge clk);
    check_val("refetch_req", mem_bus.mem_req, 1);
    check_val("refetch_addr", mem_bus.mem_addr, 80);
    pix_check("unfilled_line1", 17, 1'b1, 16'h0000);
    ready_mode = 1;
    wait_fetch(r0);
    check_addrs("addr_line2", a0, 80);
    check_val("underflow_sticky", underflow, 1);

    // reset with one beat in flight
    ready_mode = 0; lat = 6;
    line_start(2);
    pix_check("px33_line2", 33, 1'b1, word_of(82));
    a0 = acc_cnt; r0 = ret_cnt;
    single_left = 1; ready_mode = 3;
    n = 0;
    while (acc_cnt == a0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check_val("single_accept", acc_cnt - a0, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_mem_req", mem_bus.mem_req, 0);
    check_val("midrst_mem_addr", mem_bus.mem_addr, 0);
    check_val("midrst_pixel_out", pixel_out, 0);
    check_val("midrst_underflow", underflow, 0);
    repeat (10) @(negedge clk);
    check_val("late_beat_returned", ret_cnt - r0, 1);
    check_val("late_beat_no_req", mem_bus.mem_req, 0);
    check_val("late_beat_pixel", pixel_out, 0);

    // clean fetch after reset
    ready_mode = 1; lat = 1; a0 = acc_cnt; r0 = ret_cnt;
    line_start(19);
    wait_fetch(r0);
    check_addrs("addr_line20", a0, 800);
    line_start(20);
    pix_check("px5_line20", 5, 1'b1, word_of(800));
    pix_check("px639_line20", 639, 1'b1, word_of(839));
    pix_check("nodisp_line20", 639, 1'b0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
